// File: rtl/alu_sequencer.sv
// Accumulator sequencer for an external 16-bit ALU: each accepted command runs
// IDLE -> EXEC -> DONE, with results and flags retired on the EXEC->DONE edge.
module alu_sequencer #(
    parameter logic [15:0] ACC_INIT = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [15:0] cmd_data,
    output logic [3:0]  alu_aluc,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic        alu_cy_in,
    input  logic [15:0] alu_z,
    input  logic        alu_cy_out,
    output logic [15:0] acc,
    output logic        cy_flag,
    output logic        zero_flag,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  op;
    logic [15:0] operand;
    logic        accept;
    logic        write_acc;
    logic        cy_next;

    assign accept    = cmd_valid && cmd_ready;
    assign alu_a     = acc;
    assign alu_b     = operand;
    assign alu_cy_in = cy_flag;

    // NOTE: every output of this block gets a default before the case, so no
    // path can leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        alu_aluc   = 4'b0000;
        done       = 1'b0;
        case (state)
            IDLE: begin
                // Held low while reset is asserted so nothing is accepted then.
                cmd_ready = !reset;
                if (cmd_valid && !reset) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                alu_aluc   = op;
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Retire decode: which ops write acc/zero_flag and what cy_flag becomes.
    always_comb begin
        write_acc = 1'b0;
        cy_next   = cy_flag;
        case (op)
            4'b0100, 4'b0101: begin
                write_acc = 1'b1;
                cy_next   = alu_cy_out;
            end
            4'b1011: cy_next = 1'b0;
            4'b1100: cy_next = 1'b1;
            4'b1101, 4'b1110, 4'b1111: begin
                write_acc = 1'b0;
            end
            default: write_acc = 1'b1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; op 0101 relies on this to see the old cy_flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            op        <= 4'b0000;
            operand   <= 16'h0000;
            acc       <= ACC_INIT;
            cy_flag   <= 1'b0;
            zero_flag <= (ACC_INIT == 16'h0000);
        end else begin
            state <= state_next;
            if (accept) begin
                op      <= cmd_op;
                operand <= cmd_data;
            end
            if (state == EXEC) begin
                if (write_acc) begin
                    acc       <= alu_z;
                    zero_flag <= (alu_z == 16'h0000);
                end
                cy_flag <= cy_next;
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: a behavioural ALU drives the result
// inputs, and an arithmetic model of the accumulator predicts every result.
module tb_alu_sequencer;

    localparam logic [15:0] ACC_INIT_TB = 16'h00AA;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [15:0] cmd_data;
    logic [3:0]  alu_aluc;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic        alu_cy_in;
    logic [15:0] alu_z;
    logic        alu_cy_out;
    logic [15:0] acc;
    logic        cy_flag;
    logic        zero_flag;
    logic        done;

    int checks   = 0;
    int failures = 0;

    logic [15:0] m_acc;
    bit          m_cy;
    bit          m_zero;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] data;
        logic [15:0] acc;
        logic        cy;
        logic        zero;
    } vec_t;

    vec_t vecs [24];

    alu_sequencer #(.ACC_INIT(ACC_INIT_TB)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .alu_aluc   (alu_aluc),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_cy_in  (alu_cy_in),
        .alu_z      (alu_z),
        .alu_cy_out (alu_cy_out),
        .acc        (acc),
        .cy_flag    (cy_flag),
        .zero_flag  (zero_flag),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU; non-carry ops return an inverted carry so stray writes show up.
    always_comb begin
        alu_cy_out = ~alu_cy_in;
        case (alu_aluc)
            4'h0: alu_z = alu_a & alu_b;
            4'h1: alu_z = alu_b;
            4'h2: alu_z = alu_a | alu_b;
            4'h3: alu_z = alu_a ^ alu_b;
            4'h4: {alu_cy_out, alu_z} = {1'b0, alu_a} + {1'b0, alu_b};
            4'h5: {alu_cy_out, alu_z} = {1'b0, alu_a} + {1'b0, alu_b} + {16'h0000, alu_cy_in};
            4'h6: alu_z = alu_a - alu_b;
            4'h7: alu_z = ~alu_a;
            4'h8: alu_z = alu_a << 1;
            4'h9: alu_z = alu_a | alu_b;
            4'hA: alu_z = alu_a >> 1;
            default: alu_z = ~alu_a ^ alu_b;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_apply(input logic [3:0] o, input logic [15:0] d);
        int a;
        int b;
        int r;
        bit wr;
        a  = int'(m_acc);
        b  = int'(d);
        r  = 0;
        wr = 1'b1;
        case (o)
            4'h0: r = a & b;
            4'h1: r = b;
            4'h2: r = a | b;
            4'h3: r = a ^ b;
            4'h4: begin r = a + b; m_cy = (r > 65535); end
            4'h5: begin r = a + b + (m_cy ? 1 : 0); m_cy = (r > 65535); end
            4'h6: r = a - b + 65536;
            4'h7: r = 65535 - a;
            4'h8: r = a * 2;
            4'h9: r = a | b;
            4'hA: r = a / 2;
            4'hB: begin wr = 1'b0; m_cy = 1'b0; end
            4'hC: begin wr = 1'b0; m_cy = 1'b1; end
            default: wr = 1'b0;
        endcase
        if (wr) begin
            m_acc  = 16'(r % 65536);
            m_zero = ((r % 65536) == 0);
        end
    endtask

    task automatic model_reset();
        m_acc  = ACC_INIT_TB;
        m_cy   = 1'b0;
        m_zero = (ACC_INIT_TB == 16'h0000);
    endtask

    task automatic check_state(input string tag);
        check({tag, "_acc"},  32'(acc),       32'(m_acc));
        check({tag, "_cy"},   32'(cy_flag),   32'(m_cy));
        check({tag, "_zero"}, 32'(zero_flag), 32'(m_zero));
    endtask

    // Called at a negedge in IDLE; returns at the negedge after the command retires.
    task automatic run_cmd(input logic [3:0] o, input logic [15:0] d);
        int n;
        n = 0;
        while (!cmd_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) check("ready_timeout", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = o;
        cmd_data  = d;
        @(negedge clk);
        // Junk command held during EXEC and DONE must be ignored.
        cmd_op   = 4'($urandom_range(0, 15));
        cmd_data = 16'($urandom);
        check("exec_aluc",  32'(alu_aluc),  32'(o));
        check("exec_a",     32'(alu_a),     32'(m_acc));
        check("exec_b",     32'(alu_b),     32'(d));
        check("exec_cyin",  32'(alu_cy_in), 32'(m_cy));
        check("exec_ready", 32'(cmd_ready), 32'd0);
        check("exec_done",  32'(done),      32'd0);
        model_apply(o, d);
        @(negedge clk);
        check("done_pulse", 32'(done),      32'd1);
        check("done_aluc",  32'(alu_aluc),  32'd0);
        check("done_b",     32'(alu_b),     32'(d));
        check("done_ready", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        check("idle_done",  32'(done),      32'd0);
        check("idle_ready", 32'(cmd_ready), 32'd1);
        check("idle_aluc",  32'(alu_aluc),  32'd0);
        cmd_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0]  accepts;
        int          dones;
        logic [15:0] d;

        vecs[0]  = '{4'h1, 16'h1234, 16'h1234, 1'b0, 1'b0};
        vecs[1]  = '{4'h4, 16'h0001, 16'h1235, 1'b0, 1'b0};
        vecs[2]  = '{4'h1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0};
        vecs[3]  = '{4'h4, 16'h0001, 16'h0000, 1'b1, 1'b1};
        vecs[4]  = '{4'h5, 16'h0000, 16'h0001, 1'b0, 1'b0};
        vecs[5]  = '{4'h1, 16'h00AA, 16'h00AA, 1'b0, 1'b0};
        vecs[6]  = '{4'hC, 16'h0000, 16'h00AA, 1'b1, 1'b0};
        vecs[7]  = '{4'hB, 16'h0000, 16'h00AA, 1'b0, 1'b0};
        vecs[8]  = '{4'hC, 16'h1234, 16'h00AA, 1'b1, 1'b0};
        vecs[9]  = '{4'hE, 16'h5555, 16'h00AA, 1'b1, 1'b0};
        vecs[10] = '{4'h5, 16'h0001, 16'h00AC, 1'b0, 1'b0};
        vecs[11] = '{4'h7, 16'h0000, 16'hFF53, 1'b0, 1'b0};
        vecs[12] = '{4'h0, 16'h0000, 16'h0000, 1'b0, 1'b1};
        vecs[13] = '{4'hF, 16'hFFFF, 16'h0000, 1'b0, 1'b1};
        vecs[14] = '{4'hD, 16'h0001, 16'h0000, 1'b0, 1'b1};
        vecs[15] = '{4'h1, 16'h8001, 16'h8001, 1'b0, 1'b0};
        vecs[16] = '{4'h8, 16'h0000, 16'h0002, 1'b0, 1'b0};
        vecs[17] = '{4'hA, 16'h0000, 16'h0001, 1'b0, 1'b0};
        vecs[18] = '{4'hC, 16'h0000, 16'h0001, 1'b1, 1'b0};
        vecs[19] = '{4'h6, 16'h0001, 16'h0000, 1'b1, 1'b1};
        vecs[20] = '{4'h9, 16'h0000, 16'h0000, 1'b1, 1'b1};
        vecs[21] = '{4'h3, 16'h0005, 16'h0005, 1'b1, 1'b0};
        vecs[22] = '{4'h2, 16'h00F0, 16'h00F5, 1'b1, 1'b0};
        vecs[23] = '{4'h5, 16'hFF0A, 16'h0000, 1'b1, 1'b1};

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 4'h0;
        cmd_data  = 16'h0000;
        model_reset();

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_acc",   32'(acc),       32'(ACC_INIT_TB));
        check("rst_cy",    32'(cy_flag),   32'd0);
        check("rst_zero",  32'(zero_flag), 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd0);
        check("rst_done",  32'(done),      32'd0);
        check("rst_aluc",  32'(alu_aluc),  32'd0);
        check("rst_b",     32'(alu_b),     32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(cmd_ready), 32'd1);

        // Directed table: load/add, carry chain, flag ops, NOPs, every opcode
        for (int i = 0; i < 24; i++) begin
            run_cmd(vecs[i].op, vecs[i].data);
            check($sformatf("vec%0d_acc", i),  32'(acc),       32'(vecs[i].acc));
            check($sformatf("vec%0d_cy", i),   32'(cy_flag),   32'(vecs[i].cy));
            check($sformatf("vec%0d_zero", i), 32'(zero_flag), 32'(vecs[i].zero));
        end

        // Held cmd_valid: accepts only on the first IDLE cycle of each pass
        run_cmd(4'h1, 16'h0000);
        cmd_valid = 1'b1;
        cmd_op    = 4'h9;
        cmd_data  = 16'h0001;
        accepts   = '0;
        dones     = 0;
        for (int i = 0; i < 9; i++) begin
            accepts[i] = cmd_ready;
            if (done) dones++;
            if (cmd_ready) model_apply(4'h9, 16'h0001);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        check("held_accepts", 32'(accepts), 32'(9'b001001001));
        check("held_dones",   32'(dones),   32'd3);
        check("held_acc",     32'(acc),     32'h0001);
        check_state("held");

        // Randomized commands against the arithmetic model
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 4))
                0: d = 16'h0000;
                1: d = 16'hFFFF;
                2: d = 16'h0001;
                3: d = 16'h8000;
                default: d = 16'($urandom);
            endcase
            run_cmd(4'($urandom_range(0, 15)), d);
            check_state($sformatf("rnd%0d", i));
        end

        // Reset during EXEC aborts a pending op 1010
        run_cmd(4'h1, 16'h1234);
        run_cmd(4'hC, 16'h0000);
        check_state("pre_abort");
        cmd_valid = 1'b1;
        cmd_op    = 4'hA;
        cmd_data  = 16'h0000;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("abort_exec_aluc", 32'(alu_aluc), 32'hA);
        #1 reset = 1'b1;
        #1;
        model_reset();
        check_state("abort_exec");
        check("abort_exec_done",  32'(done),      32'd0);
        check("abort_exec_ready", 32'(cmd_ready), 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("abort_hold_done",  32'(done),      32'd0);
            check("abort_hold_ready", 32'(cmd_ready), 32'd0);
        end
        reset = 1'b0;
        @(negedge clk);
        check("abort_release_ready", 32'(cmd_ready), 32'd1);
        check("abort_release_done",  32'(done),      32'd0);
        check_state("abort_release");
        run_cmd(4'h4, 16'h0001);
        check("after_abort_acc", 32'(acc), 32'h00AB);
        check_state("after_abort");

        // Reset during DONE kills the done pulse and restores ACC_INIT
        cmd_valid = 1'b1;
        cmd_op    = 4'h1;
        cmd_data  = 16'h5A5A;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("done_phase_pulse", 32'(done), 32'd1);
        check("done_phase_acc",   32'(acc),  32'h5A5A);
        #1 reset = 1'b1;
        #1;
        model_reset();
        check("done_abort_done", 32'(done), 32'd0);
        check_state("done_abort");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("done_abort_ready", 32'(cmd_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have parameter ACC_INIT, default 16'h0000, accumulator value loaded on reset.
REQ-002 The block SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port cmd_valid  input  1  command present on cmd_op/cmd_data.
REQ-005 The block SHALL have port cmd_ready  output  1  sequencer can accept a command this cycle.
REQ-006 The block SHALL have port cmd_op  input  4  ALU operation code, same encoding as the ALU aluc input.
REQ-007 The block SHALL have port cmd_data  input  16  operand presented to ALU input b.
REQ-008 The block SHALL have port alu_aluc  output  4  drives ALU aluc.
REQ-009 The block SHALL have port alu_a  output  16  drives ALU a; always equals acc.
REQ-010 The block SHALL have port alu_b  output  16  drives ALU b; always equals the latched operand register.
REQ-011 The block SHALL have port alu_cy_in  output  1  drives ALU cy_in; always equals cy_flag.
REQ-012 The block SHALL have port alu_z  input  16  ALU result.
REQ-013 The block SHALL have port alu_cy_out  input  1  ALU carry out.
REQ-014 The block SHALL have port acc  output  16  accumulator register.
REQ-015 The block SHALL have port cy_flag  output  1  carry flag register.
REQ-016 The block SHALL have port zero_flag  output  1  registered, high when acc == 0.
REQ-017 The block SHALL have port done  output  1  one-cycle pulse, command retired.

Function
REQ-018 The FSM SHALL have states IDLE, EXEC, DONE; IDLE->EXEC on cmd_valid & cmd_ready; EXEC->DONE unconditionally; DONE->IDLE unconditionally.
REQ-019 cmd_ready SHALL be 1 only in IDLE with reset low; cmd_valid outside IDLE SHALL be ignored and the command SHALL NOT be latched.
REQ-020 On the accepting edge, cmd_op and cmd_data SHALL be latched into op and operand registers.
REQ-021 alu_aluc SHALL equal the latched op in EXEC and 4'b0000 in IDLE and DONE.
REQ-022 On the EXEC->DONE edge: ops 0000-0111 and 1000-1010 SHALL write alu_z to acc; zero_flag SHALL be updated to (alu_z == 0) on the same edge.
REQ-023 On that edge cy_flag SHALL take alu_cy_out for ops 0100 and 0101, be cleared for 1011, set for 1100, and remain unchanged for all other ops.
REQ-024 Ops 1011 and 1100 SHALL NOT modify acc or zero_flag; ops 1101-1111 SHALL be NOPs leaving acc, cy_flag and zero_flag unchanged but still completing through DONE.
REQ-025 done SHALL be 1 exactly during DONE; latency SHALL be accept edge N, results visible after edge N+1, done high in cycle N+1..N+2, cmd_ready high again after edge N+2.
REQ-026 Maximum throughput SHALL be one command per 3 cycles; back-to-back valid SHALL be accepted on the first IDLE cycle.
REQ-027 Op 0101 SHALL use the cy_flag value held before the EXEC->DONE edge as cy_in (chained add).
REQ-028 All arithmetic SHALL be 16 bits with the carry only in cy_flag; 16'hFFFF + 1 SHALL give acc = 0, cy_flag = 1, zero_flag = 1.

Reset
REQ-029 While reset is high: state IDLE, acc = ACC_INIT, cy_flag = 0, zero_flag = (ACC_INIT == 0), done = 0, cmd_ready = 0, op and operand registers = 0.
REQ-030 Reset asserted in EXEC or DONE SHALL abort the command with no write to acc or cy_flag and no done pulse.
REQ-031 After reset deasserts, cmd_ready SHALL be 1 in the first cycle in IDLE.

Verification
REQ-032 Load then add: op 0001 data 16'h1234, then op 0100 data 16'h0001 -> acc 16'h1235, cy_flag 0, zero_flag 0, two done pulses.
REQ-033 Carry chain: acc 16'hFFFF, op 0100 data 16'h0001 -> acc 0, cy 1, zero 1; then op 0101 data 0 -> acc 16'h0001, cy 0.
REQ-034 Flag ops: acc 16'h00AA, op 1100 -> cy 1, acc 16'h00AA; op 1011 -> cy 0; op 1110 -> no change, done pulses.
REQ-035 Handshake: cmd_valid held high with op 1001 for 9 cycles -> exactly 3 accepts at 3-cycle spacing, acc 16'h0001.
REQ-036 Reset mid-EXEC with op 1010 pending -> acc = ACC_INIT, cy 0, no done pulse, cmd_ready 1 one cycle after release.
